tmip_out_deser: RTL and testbench
=================================

// Module: tmip_out_deser
// PURPOSE
//   Downstream stage of TMIP. Captures TMIP's serial result stream (out_valid/out_value, MSB-first),
//   reassembles it into WORD_W-bit words and buffers them in a FIFO_DEPTH-entry first-word-fall-through FIFO.
//   Words are presented on a valid/ready interface.
//   Reports per-frame word count, partial-word errors and FIFO overflow.
// PARAMETERS
//   WORD_W      20  bits per result word (TMIP convolution/correlation result width)
//   FIFO_DEPTH  16  buffer entries, power of two, >=2
//   CNT_W       16  width of per-frame word counter (saturating)
// PORTS
//   clk          in   1       single clock, all state on rising edge
//   rst_n        in   1       asynchronous active-low reset
//   ser_valid    in   1       TMIP out_valid; high while a frame's bits stream
//   ser_bit      in   1       TMIP out_value; sampled only when ser_valid=1
//   clr_err      in   1       synchronous clear of sticky error flags
//   word_ready   in   1       consumer accepts word_data this cycle
//   word_valid   out  1       FIFO head valid
//   word_data    out  WORD_W  FIFO head word
//   fifo_cnt     out  $clog2(FIFO_DEPTH)+1  current occupancy
//   frame_done   out  1       one-cycle pulse at end of frame
//   frame_words  out  CNT_W   complete words in last frame; valid with and after frame_done
//   err_partial  out  1       sticky: frame ended mid-word
//   err_ovf      out  1       sticky: word dropped because FIFO full
// BEHAVIOUR
//   Reset: FSM=IDLE; bit_cnt=0; shift reg=0; FIFO empty; all outputs 0.
//   Reset mid-frame: everything discarded, no frame_done.
//   FSM IDLE->SHIFT on ser_valid=1 (that bit already shifted in). SHIFT stays while ser_valid=1.
//   FSM SHIFT->IDLE on ser_valid=0: frame_done pulses on that same edge, so it is visible the following cycle.
//   Shift: sr <= {sr[WORD_W-2:0], ser_bit}; bit_cnt increments 0..WORD_W-1 and wraps.
//   Word complete when bit_cnt==WORD_W-1 and ser_valid=1: push {sr[WORD_W-2:0], ser_bit}; frame word counter +1.
//   Frame word counter saturates at 2^CNT_W-1. It clears when a new frame starts in IDLE.
//   Latency: word_valid rises 1 cycle after the clock edge that samples the last bit (FIFO previously empty).
//   Pop occurs when word_valid & word_ready. word_data holds stable while word_valid=1 and word_ready=0.
//   Push and pop in the same cycle: both happen; occupancy unchanged. Also legal when FIFO is full.
//   Push when full without pop: word dropped, err_ovf <= 1. The frame counter still counts the word.
//   Frame end with bit_cnt!=0: partial bits discarded, err_partial <= 1, bit_cnt <= 0.
//   frame_words excludes partial words.
//   clr_err=1 clears both sticky flags. A same-cycle new error wins (flag stays 1).
//   ser_valid gaps of one cycle count as frame end; a new frame starts clean.
//   Pointers: $clog2(FIFO_DEPTH)-bit, wrap naturally; full/empty from fifo_cnt.
// CONFIGURATION
//   TMIP_DESER_MAX_EN defined: adds output frame_max [WORD_W-1:0].
//     frame_max = largest complete word of last frame (unsigned), updated with frame_done.
//     It is 0 after reset and 0 for a frame with no complete words.
//   TMIP_DESER_MAX_EN undefined: port and logic absent; all other behaviour identical.
// TESTING
//   Reset: rst_n low mid-frame at bit 7 -> all outputs 0, FIFO empty, no frame_done after release.
//   Basic frame: word_ready=1, 40 bits, ser_valid high, words 20'h12345 and 20'hABCDE.
//     -> word_data 20'h12345 then 20'hABCDE, each 1 cycle after its last bit.
//     -> frame_done 1 pulse, frame_words=2.
//   Backpressure/overflow: word_ready=0, stream 17 words, FIFO_DEPTH=16.
//     -> fifo_cnt=16, err_ovf=1, frame_words=17.
//     -> drain returns the first 16 words in order.
//   Full push+pop: FIFO full, word_ready=1 on the cycle the 17th word completes.
//     -> no drop, err_ovf=0, fifo_cnt stays 16.
//   Partial: 30 bits then ser_valid=0 -> 1 word out, err_partial=1, frame_words=1; clr_err pulse -> flag 0.
//   MAX_EN: words 5, 20'hFFFFF, 3 -> frame_max=20'hFFFFF at frame_done; next empty frame -> frame_max=0.

Source files
------------

// File: rtl/tmip_out_deser.sv
// Deserializes TMIP's MSB-first result stream into WORD_W-bit words behind a FWFT FIFO.
// Optional TMIP_DESER_MAX_EN adds frame_max (largest complete word of the last frame).
module tmip_out_deser #(
  parameter int WORD_W     = 20,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ser_valid,
  input  logic                          ser_bit,
  input  logic                          clr_err,
  input  logic                          word_ready,
  output logic                          word_valid,
  output logic [WORD_W-1:0]             word_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          frame_done,
  output logic [CNT_W-1:0]              frame_words,
  output logic                          err_partial,
`ifdef TMIP_DESER_MAX_EN
  output logic                          err_ovf,
  output logic [WORD_W-1:0]             frame_max
`else
  output logic                          err_ovf
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t              r_state, w_state_nxt;
  logic [WORD_W-1:0]   r_sr;
  logic [BW-1:0]       r_bit_cnt;
  logic [CNT_W-1:0]    r_word_cnt;
  logic [CNT_W-1:0]    r_frame_words;
  logic                r_frame_done;
  logic                r_err_partial;
  logic                r_err_ovf;
  logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_cnt;

  logic                w_frame_start;
  logic                w_frame_end;
  logic                w_word_done;
  logic [WORD_W-1:0]   w_word;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (ser_valid) begin
          w_state_nxt   = SHIFT;
          w_frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (!ser_valid) begin
          w_state_nxt = IDLE;
          w_frame_end = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_word      = {r_sr[WORD_W-2:0], ser_bit};
  assign w_word_done = ser_valid && (r_bit_cnt == BW'(WORD_W - 1));
  assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop       = word_valid && word_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_push      = w_word_done && (!w_full || w_pop);
  assign w_drop      = w_word_done && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_frame_words <= '0;
      r_frame_done  <= 1'b0;
      r_err_partial <= 1'b0;
      r_err_ovf     <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (ser_valid) begin
        r_sr      <= w_word;
        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BW'(1);
      end else begin
        r_bit_cnt <= '0;
      end
      if (w_frame_start)
        r_word_cnt <= w_word_done ? CNT_W'(1) : '0;
      else if (w_word_done && (r_word_cnt != '1))
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (w_frame_end)
        r_frame_words <= r_word_cnt;
      r_err_partial <= (r_err_partial && !clr_err) || (w_frame_end && (r_bit_cnt != '0));
      r_err_ovf     <= (r_err_ovf && !clr_err) || w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef TMIP_DESER_MAX_EN
  logic [WORD_W-1:0] r_cur_max;
  logic [WORD_W-1:0] r_frame_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_max   <= '0;
      r_frame_max <= '0;
    end else begin
      if (w_frame_start)
        r_cur_max <= w_word_done ? w_word : '0;
      else if (w_word_done && (w_word > r_cur_max))
        r_cur_max <= w_word;
      if (w_frame_end)
        r_frame_max <= r_cur_max;
    end
  end

  assign frame_max = r_frame_max;
`endif

  always_comb begin
    word_valid = (r_cnt != '0);
    word_data  = word_valid ? r_mem[r_rd_ptr] : '0;
  end

  assign fifo_cnt    = r_cnt;
  assign frame_done  = r_frame_done;
  assign frame_words = r_frame_words;
  assign err_partial = r_err_partial;
  assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_tmip_out_deser.sv
// Directed bench for tmip_out_deser: reset, basic frame, overflow, full push+pop, partial frame.
module tb_tmip_out_deser;

  localparam int WORD_W = 20;

  logic              clk = 1'b0;
  logic              rst_n, ser_valid, ser_bit, clr_err, word_ready;
  logic              word_valid, frame_done, err_partial, err_ovf;
  logic [WORD_W-1:0] word_data;
  logic [4:0]        fifo_cnt;
  logic [15:0]       frame_words;
`ifdef TMIP_DESER_MAX_EN
  logic [WORD_W-1:0] frame_max;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  tmip_out_deser #(.WORD_W(20), .FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_bit(ser_bit),
    .clr_err(clr_err), .word_ready(word_ready), .word_valid(word_valid),
    .word_data(word_data), .fifo_cnt(fifo_cnt), .frame_done(frame_done),
    .frame_words(frame_words), .err_partial(err_partial),
`ifdef TMIP_DESER_MAX_EN
    .err_ovf(err_ovf), .frame_max(frame_max)
`else
    .err_ovf(err_ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ser_valid = 1'b1;
    ser_bit   = b;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    for (int i = WORD_W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic end_frame();
    @(negedge clk);
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
  endtask

  function automatic logic [WORD_W-1:0] pat(input int i);
    return 20'hA5000 + 20'(i);
  endfunction

  task automatic drain(input int first, input int n);
    @(negedge clk);
    word_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", 32'(word_valid), 32'd1);
      check("drain_data", 32'(word_data), 32'(pat(first + i)));
      @(negedge clk);
    end
    check("drain_empty", 32'(word_valid), 32'd0);
    word_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0; clr_err = 1'b0; word_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-frame at bit 7
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0; ser_valid = 1'b0;
    #1;
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_data", 32'(word_data), 32'd0);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_words", 32'(frame_words), 32'd0);
    check("rst_errs", {30'd0, err_partial, err_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'(frame_done), 32'd0);
    end

    // Basic frame
    word_ready = 1'b1;
    send_word(20'h12345);
    check("basic_lat0", 32'(word_valid), 32'd0);
    @(posedge clk); #1;
    check("basic_v1", 32'(word_valid), 32'd1);
    check("basic_d1", 32'(word_data), 32'h12345);
    send_word(20'hABCDE);
    check("basic_lat1", 32'(word_valid), 32'd0);
    @(posedge clk); #1;
    check("basic_v2", 32'(word_valid), 32'd1);
    check("basic_d2", 32'(word_data), 32'hABCDE);
    end_frame();
    @(posedge clk); #1;
    check("basic_done", 32'(frame_done), 32'd1);
    check("basic_words", 32'(frame_words), 32'd2);
    check("basic_part", 32'(err_partial), 32'd0);
    @(posedge clk); #1;
    check("basic_done_pulse", 32'(frame_done), 32'd0);
    check("basic_words_hold", 32'(frame_words), 32'd2);
    check("basic_empty", 32'(fifo_cnt), 32'd0);

    // Backpressure and overflow
    @(negedge clk);
    word_ready = 1'b0;
    for (int i = 0; i < 17; i++) send_word(pat(i));
    @(posedge clk); #1;
    check("ovf_cnt", 32'(fifo_cnt), 32'd16);
    check("ovf_flag", 32'(err_ovf), 32'd1);
    end_frame();
    @(posedge clk); #1;
    check("ovf_done", 32'(frame_done), 32'd1);
    check("ovf_words", 32'(frame_words), 32'd17);
    drain(0, 16);
    check("ovf_sticky", 32'(err_ovf), 32'd1);
    pulse_clr();
    check("ovf_clr", 32'(err_ovf), 32'd0);

    // Full FIFO, push and pop on the same edge
    for (int i = 0; i < 16; i++) send_word(pat(i));
    for (int i = WORD_W - 1; i >= 1; i--) send_bit(pat(16)[i]);
    @(negedge clk);
    ser_bit    = pat(16)[0];
    word_ready = 1'b1;
    @(posedge clk); #1;
    check("pp_cnt", 32'(fifo_cnt), 32'd16);
    check("pp_ovf", 32'(err_ovf), 32'd0);
    check("pp_head", 32'(word_data), 32'(pat(1)));
    end_frame();
    word_ready = 1'b0;
    @(posedge clk); #1;
    check("pp_words", 32'(frame_words), 32'd17);
    drain(1, 16);

    // Partial trailing word
    @(negedge clk);
    word_ready = 1'b1;
    send_word(20'h0F0F1);
    @(posedge clk); #1;
    check("part_data", 32'(word_data), 32'h0F0F1);
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    end_frame();
    @(posedge clk); #1;
    check("part_done", 32'(frame_done), 32'd1);
    check("part_words", 32'(frame_words), 32'd1);
    check("part_flag", 32'(err_partial), 32'd1);
    check("part_empty", 32'(fifo_cnt), 32'd0);
    pulse_clr();
    check("part_clr", 32'(err_partial), 32'd0);

`ifdef TMIP_DESER_MAX_EN
    send_word(20'h00005);
    send_word(20'hFFFFF);
    send_word(20'h00003);
    end_frame();
    @(posedge clk); #1;
    check("max_done", 32'(frame_done), 32'd1);
    check("max_val", 32'(frame_max), 32'hFFFFF);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    end_frame();
    @(posedge clk); #1;
    check("max_empty", 32'(frame_max), 32'd0);
    check("max_empty_words", 32'(frame_words), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
